// File: rtl/box_pkg.sv
// box_pkg: shared types, geometry constants and the position step helper
// used by the box controller.
//   state_t   : update sequencer states
//   CIDX_W    : colour index width, derived from the palette size
//   step_pos  : one-axis move with clamping to the visible area
package box_pkg;

  typedef enum logic [1:0] {IDLE, APPLY_X, APPLY_Y, APPLY_C} state_t;

  localparam logic [11:0] H_ACTIVE = 12'd640;
  localparam logic [11:0] V_ACTIVE = 12'd480;
  localparam logic [11:0] BOX_W    = 12'd64;
  localparam logic [11:0] BOX_H    = 12'd64;
  localparam logic [11:0] STEP     = 12'd8;
  localparam logic [11:0] B1_X0    = 12'd64;
  localparam logic [11:0] B1_Y0    = 12'd64;
  localparam logic [11:0] B2_X0    = 12'd320;
  localparam logic [11:0] B2_Y0    = 12'd240;
  localparam logic [11:0] X_MAX    = H_ACTIVE - BOX_W;
  localparam logic [11:0] Y_MAX    = V_ACTIVE - BOX_H;

  localparam int NUM_COLORS = 8;
  localparam int CIDX_W     = $clog2(NUM_COLORS);
  localparam logic [CIDX_W-1:0] CIDX_MAX = CIDX_W'(NUM_COLORS - 1);

  // Button bit positions in the internal button vector.
  localparam int BTN_SEL1  = 0;
  localparam int BTN_SEL2  = 1;
  localparam int BTN_COL1  = 2;
  localparam int BTN_COL2  = 3;
  localparam int BTN_UP    = 4;
  localparam int BTN_DOWN  = 5;
  localparam int BTN_LEFT  = 6;
  localparam int BTN_RIGHT = 7;

  // Move one coordinate by STEP. dec/inc together cancel. The increment is
  // formed in 13 bits so the sum cannot wrap before the clamp is applied.
  function automatic logic [11:0] step_pos(input logic [11:0] pos,
                                           input logic dec,
                                           input logic inc,
                                           input logic [11:0] max_pos);
    logic [12:0] wide;
    wide = {1'b0, pos} + {1'b0, STEP};
    step_pos = pos;
    if (dec && !inc) begin
      step_pos = (pos >= STEP) ? pos - STEP : 12'd0;
    end else if (inc && !dec) begin
      step_pos = (wide > {1'b0, max_pos}) ? max_pos : wide[11:0];
    end
  endfunction

endpackage

// File: rtl/box_ctrl_btn_edge.sv
// btn_edge: rising-edge detector for one synchronised, debounced button.
//   rfr_clk : clock
//   reset   : synchronous active-high reset
//   in      : button level
//   rise    : high for the cycle in which 'in' is 1 and was 0 last cycle
// The previous-value register resets to 0, so a button held through reset
// release produces exactly one rise.
module btn_edge (
  input  logic rfr_clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic prev_reg;

  always_ff @(posedge rfr_clk) begin
    if (reset) begin
      prev_reg <= 1'b0;
    end else begin
      prev_reg <= in;
    end
  end

  assign rise = in & ~prev_reg;

endmodule

// File: rtl/box_ctrl.sv
// box_ctrl: position/colour state of two on-screen boxes. Button presses
// are captured at any time into sticky pending bits and applied once per
// frame at the first vblank pixel, one axis/attribute per cycle.
//   rfr_clk, reset             : clock, synchronous active-high reset
//   pixel_cnt, line_cnt        : raster position from the timing generator
//   move_box1/2                : select the box the direction buttons move
//   dColor_box1/2              : step the colour index of a box
//   move_up/down/left/right    : move the selected box by STEP
//   b1_x,b1_y,b2_x,b2_y        : box top-left edges
//   b1_cidx,b2_cidx            : palette index per box
//   active_box                 : 0 = box 1 selected, 1 = box 2
//   busy                       : high while an update is being applied
module box_ctrl
  import box_pkg::*;
(
  input  logic              rfr_clk,
  input  logic              reset,
  input  logic [11:0]       pixel_cnt,
  input  logic [11:0]       line_cnt,
  input  logic              move_box1,
  input  logic              move_box2,
  input  logic              dColor_box1,
  input  logic              dColor_box2,
  input  logic              move_up,
  input  logic              move_down,
  input  logic              move_left,
  input  logic              move_right,
  output logic [11:0]       b1_x,
  output logic [11:0]       b1_y,
  output logic [11:0]       b2_x,
  output logic [11:0]       b2_y,
  output logic [CIDX_W-1:0] b1_cidx,
  output logic [CIDX_W-1:0] b2_cidx,
  output logic              active_box,
  output logic              busy
);

  logic [7:0] btn_in;
  logic [7:0] btn_rise;

  assign btn_in = {move_right, move_left, move_down, move_up,
                   dColor_box2, dColor_box1, move_box2, move_box1};

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_edge
      btn_edge u_edge (
        .rfr_clk (rfr_clk),
        .reset   (reset),
        .in      (btn_in[gi]),
        .rise    (btn_rise[gi])
      );
    end
  endgenerate

  state_t state_reg, state_next;

  logic [11:0]       box_x_reg [2];
  logic [11:0]       box_y_reg [2];
  logic [CIDX_W-1:0] cidx_reg  [2];
  logic              active_box_reg;
  logic              busy_reg;

  // Direction bits are {right, left, down, up}; colour bits are {box2, box1}.
  logic [3:0] pend_dir_reg, work_dir_reg, pend_dir_next;
  logic [1:0] pend_col_reg, work_col_reg, pend_col_next;
  logic       pend_box_reg, work_box_reg;
  logic       pend_box_load;

  logic frame_tick;
  logic pend_any;
  logic snapshot;
  logic apply_x, apply_y, apply_c;
  logic busy_next;

  assign frame_tick = (line_cnt == V_ACTIVE) && (pixel_cnt == 12'd0);
  assign pend_any   = (|pend_dir_reg) || (|pend_col_reg);

  // State register
  always_ff @(posedge rfr_clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (frame_tick && pend_any) state_next = APPLY_X;
      APPLY_X: state_next = APPLY_Y;
      APPLY_Y: state_next = APPLY_C;
      APPLY_C: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs and pending-bit bookkeeping
  always_comb begin
    snapshot  = (state_reg == IDLE) && frame_tick && pend_any;
    apply_x   = (state_reg == APPLY_X);
    apply_y   = (state_reg == APPLY_Y);
    apply_c   = (state_reg == APPLY_C);
    busy_next = (state_next != IDLE);
    // Snapshot clears pending, but an edge in the same cycle still lands.
    pend_dir_next = (snapshot ? 4'd0 : pend_dir_reg) | btn_rise[BTN_RIGHT:BTN_UP];
    pend_col_next = (snapshot ? 2'd0 : pend_col_reg) | btn_rise[BTN_COL2:BTN_COL1];
    // The target box is fixed by the first direction press of a batch.
    pend_box_load = ((snapshot ? 4'd0 : pend_dir_reg) == 4'd0) &&
                    (|btn_rise[BTN_RIGHT:BTN_UP]);
  end

  always_ff @(posedge rfr_clk) begin
    if (reset) begin
      box_x_reg[0]   <= B1_X0;
      box_y_reg[0]   <= B1_Y0;
      box_x_reg[1]   <= B2_X0;
      box_y_reg[1]   <= B2_Y0;
      cidx_reg[0]    <= '0;
      cidx_reg[1]    <= '0;
      active_box_reg <= 1'b0;
      busy_reg       <= 1'b0;
      pend_dir_reg   <= 4'd0;
      pend_col_reg   <= 2'd0;
      pend_box_reg   <= 1'b0;
      work_dir_reg   <= 4'd0;
      work_col_reg   <= 2'd0;
      work_box_reg   <= 1'b0;
    end else begin
      busy_reg     <= busy_next;
      pend_dir_reg <= pend_dir_next;
      pend_col_reg <= pend_col_next;
      if (pend_box_load) pend_box_reg <= active_box_reg;

      // Box 1 wins when both select buttons rise together.
      if (btn_rise[BTN_SEL1]) begin
        active_box_reg <= 1'b0;
      end else if (btn_rise[BTN_SEL2]) begin
        active_box_reg <= 1'b1;
      end

      if (snapshot) begin
        work_dir_reg <= pend_dir_reg;
        work_col_reg <= pend_col_reg;
        work_box_reg <= pend_box_reg;
      end

      if (apply_x) begin
        box_x_reg[work_box_reg] <= step_pos(box_x_reg[work_box_reg],
                                            work_dir_reg[2], work_dir_reg[3], X_MAX);
      end
      if (apply_y) begin
        box_y_reg[work_box_reg] <= step_pos(box_y_reg[work_box_reg],
                                            work_dir_reg[0], work_dir_reg[1], Y_MAX);
      end
      if (apply_c) begin
        for (int i = 0; i < 2; i++) begin
          if (work_col_reg[i]) begin
            cidx_reg[i] <= (cidx_reg[i] == CIDX_MAX) ? '0 : cidx_reg[i] + CIDX_W'(1);
          end
        end
      end
    end
  end

  assign b1_x       = box_x_reg[0];
  assign b1_y       = box_y_reg[0];
  assign b2_x       = box_x_reg[1];
  assign b2_y       = box_y_reg[1];
  assign b1_cidx    = cidx_reg[0];
  assign b2_cidx    = cidx_reg[1];
  assign active_box = active_box_reg;
  assign busy       = busy_reg;

endmodule
